// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC owner and fetch buffer feeding decode over valid/ready.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_WORD   = 32'h0007_8000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int             PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] c_full_count = (PTR_W+1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0] r_pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0] r_instr_mem [FIFO_DEPTH];

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_full_count);
  assign w_pop   = w_valid & if_ready;
  // A pop frees the head slot this edge, so a full buffer can still accept.
  assign w_push  = fetch_en & ~redirect_valid & (~w_full | w_pop);

  assign imem_addr = r_pc;
  assign if_valid  = w_valid;
  assign if_instr  = w_valid ? r_instr_mem[r_rd_ptr] : NOP_WORD;
  assign if_pc     = w_valid ? r_pc_mem[r_rd_ptr]    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + ADDR_W'(1);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Bench for instr_fetch_unit: directed phases plus random traffic, checked
// against a queue-based model of the fetch buffer and a random memory image.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0007_8000;

  typedef struct {
    logic [5:0]  pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;

  logic [31:0] mem [64];
  ent_t        q[$];
  int          mpc;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit #(
    .ADDR_W(6), .DATA_W(32), .FIFO_DEPTH(DEPTH), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk({tag, ".pc"}, {26'd0, if_pc}, {26'd0, q[0].pc});
      chk({tag, ".instr"}, if_instr, q[0].instr);
    end else begin
      chk({tag, ".pc"}, {26'd0, if_pc}, 32'd0);
      chk({tag, ".instr"}, if_instr, NOP);
    end
    chk({tag, ".addr"}, {26'd0, imem_addr}, mpc);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input string tag, input logic fe, input logic rv,
                      input logic [5:0] rpc, input logic rdy);
    bit pop, push;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    pop = (q.size() != 0) && rdy;
    if (rv) begin
      q.delete();
      mpc = int'(rpc);
    end else begin
      push = fe && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: 6'(mpc), instr: mem[mpc]});
        mpc = (mpc + 1) % 64;
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    q.delete();
    mpc = 0;
  endtask

  // Assert reset between edges, check the outputs clear at once, release later.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    model_reset();

    // Reset state
    #12;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming from pc 0
    for (int i = 0; i < 8; i++) step("stream", 1'b1, 1'b0, 6'd0, 1'b1);

    // Backpressure from reset, then release
    async_reset("rst_bp");
    for (int i = 0; i < 7; i++) step("bp_hold", 1'b1, 1'b0, 6'd0, 1'b0);
    chk("bp_addr_held", {26'd0, imem_addr}, 32'd2);
    for (int i = 0; i < 6; i++) step("bp_drain", 1'b1, 1'b0, 6'd0, 1'b1);

    // Redirect while full
    for (int i = 0; i < 3; i++) step("fill", 1'b1, 1'b0, 6'd0, 1'b0);
    step("redir7", 1'b1, 1'b1, 6'd7, 1'b1);
    chk("redir7_flush", {31'd0, if_valid}, 32'd0);
    step("redir7_first", 1'b1, 1'b0, 6'd0, 1'b0);
    chk("redir7_pc", {26'd0, if_pc}, 32'd7);
    for (int i = 0; i < 3; i++) step("redir7_run", 1'b1, 1'b0, 6'd0, 1'b1);

    // PC wrap
    step("redir62", 1'b1, 1'b1, 6'd62, 1'b1);
    for (int i = 0; i < 5; i++) step("wrap", 1'b1, 1'b0, 6'd0, 1'b1);

    // fetch_en drop drains the buffer with the pc frozen
    for (int i = 0; i < 3; i++) step("fill2", 1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 4; i++) step("fe_off", 1'b0, 1'b0, 6'd0, 1'b1);

    // Redirect still loads pc while fetch_en is low
    step("redir_fe0", 1'b0, 1'b1, 6'd20, 1'b1);
    step("fe0_idle", 1'b0, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("fe_back", 1'b1, 1'b0, 6'd0, 1'b1);

    // Async reset in the middle of streaming, then restart from 0
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 6'd0, 1'b1);
    async_reset("rst_mid");
    for (int i = 0; i < 4; i++) step("post_rst", 1'b1, 1'b0, 6'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 15) == 0),
           6'($urandom_range(0, 63)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
